tone_sequencer: RTL and testbench

Upstream command stage for the piezo square-wave tone generator.
- Accepts note commands (semitone, octave, duration in ms) over a valid/ready handshake.
- Converts each note to a full-period clock count and holds it, with an enable, for the note duration.
- Follows every note with a fixed silent articulation gap.
- The downstream tone generator counts tone_period clocks per cycle and drives the piezo pins while tone_en is high.

---
 rtl/tone_pkg.sv | 56 +++++
 rtl/tick_prescaler.sv | 46 ++++
 rtl/tone_sequencer.sv | 144 ++++++++++++++
 tb/tb_tone_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer: note codes, FSM states and the
// octave-0 tone period table used to derive the generator period.
package tone_pkg;

   localparam int unsigned TABLE_W = 20;

   localparam logic [3:0] NOTE_C    = 4'd0;
   localparam logic [3:0] NOTE_CS   = 4'd1;
   localparam logic [3:0] NOTE_D    = 4'd2;
   localparam logic [3:0] NOTE_DS   = 4'd3;
   localparam logic [3:0] NOTE_E    = 4'd4;
   localparam logic [3:0] NOTE_F    = 4'd5;
   localparam logic [3:0] NOTE_FS   = 4'd6;
   localparam logic [3:0] NOTE_G    = 4'd7;
   localparam logic [3:0] NOTE_GS   = 4'd8;
   localparam logic [3:0] NOTE_A    = 4'd9;
   localparam logic [3:0] NOTE_AS   = 4'd10;
   localparam logic [3:0] NOTE_B    = 4'd11;
   localparam logic [3:0] NOTE_REST = 4'd12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Full tone periods in 12 MHz clocks for octave 0, tuned to A0 = 27.5 Hz.
   localparam logic [TABLE_W-1:0] PERIOD_TABLE [12] = '{
      20'd733873, 20'd692684, 20'd653807, 20'd617111,
      20'd582476, 20'd549784, 20'd518927, 20'd489802,
      20'd462311, 20'd436364, 20'd411872, 20'd388756
   };

   // Each octave up halves the period; the shift truncates.
   function automatic logic [TABLE_W-1:0] note_period(input logic [3:0] note,
                                                      input logic [2:0] octave);
      logic [TABLE_W-1:0] base;
      case (note)
         NOTE_C:  base = PERIOD_TABLE[0];
         NOTE_CS: base = PERIOD_TABLE[1];
         NOTE_D:  base = PERIOD_TABLE[2];
         NOTE_DS: base = PERIOD_TABLE[3];
         NOTE_E:  base = PERIOD_TABLE[4];
         NOTE_F:  base = PERIOD_TABLE[5];
         NOTE_FS: base = PERIOD_TABLE[6];
         NOTE_G:  base = PERIOD_TABLE[7];
         NOTE_GS: base = PERIOD_TABLE[8];
         NOTE_A:  base = PERIOD_TABLE[9];
         NOTE_AS: base = PERIOD_TABLE[10];
         NOTE_B:  base = PERIOD_TABLE[11];
         default: base = '0;
      endcase
      return base >> octave;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-DIV counter producing a registered one-cycle tick;
// restart forces the count back to zero so a new note starts on a clean tick grid.
module tick_prescaler #(
   parameter int unsigned DIV = 12000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             tick_q;
   logic             tick_d;

   // Next count; tick is registered so it is high exactly while count_q sits at TERM.
   always_comb begin
      count_d = count_q;
      if (restart) begin
         count_d = '0;
      end else if (count_q == TERM) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNT_W'(1);
      end
      tick_d = (count_d == TERM);
   end

   // Counter and tick flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/tone_sequencer.sv
// Note command front end for the piezo tone generator: accepts a note, drives
// period and enable for its duration, then inserts a silent articulation gap.
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int unsigned MAIN_CLK_FREQ = 12_000_000,
   parameter int unsigned TICK_HZ       = 1000,
   parameter int unsigned GAP_TICKS     = 10,
   parameter int unsigned PERIOD_W      = 20,
   parameter int unsigned DUR_W         = 12
) (
   input  logic                CLK_IN,
   input  logic                RST_N,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [3:0]          cmd_note,
   input  logic [2:0]          cmd_octave,
   input  logic [DUR_W-1:0]    cmd_dur,
   output logic [PERIOD_W-1:0] tone_period,
   output logic                tone_en,
   output logic                busy,
   output logic                note_done
);

   localparam int unsigned DIV   = MAIN_CLK_FREQ / TICK_HZ;
   localparam int unsigned GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
   localparam int unsigned CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [PERIOD_W-1:0] tone_period_q;
   logic [PERIOD_W-1:0] tone_period_d;
   logic                tone_en_q;
   logic                tone_en_d;
   logic                note_done_q;
   logic                note_done_d;
   logic                accept;
   logic                tick;

   assign accept = cmd_valid && (state_q == IDLE);

   tick_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk     (CLK_IN),
      .rst_n   (RST_N),
      .restart (accept),
      .tick    (tick)
   );

   // Next-state logic; every output is decided here and registered below.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tone_period_d = tone_period_q;
      tone_en_d     = tone_en_q;
      note_done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            tone_en_d = 1'b0;
            if (accept) begin
               if (cmd_note < NOTE_REST) begin
                  tone_period_d = PERIOD_W'(note_period(cmd_note, cmd_octave));
               end else begin
                  tone_period_d = tone_period_q;
               end
               // A zero-length note still gets its articulation gap.
               if (cmd_dur != '0) begin
                  state_d   = PLAY;
                  cnt_d     = CNT_W'(cmd_dur);
                  tone_en_d = (cmd_note < NOTE_REST);
               end else begin
                  state_d = GAP;
                  cnt_d   = GAP_LOAD;
               end
            end else begin
               state_d = IDLE;
            end
         end
         PLAY: begin
            if (tick) begin
               if (cnt_q == CNT_ONE) begin
                  state_d   = GAP;
                  cnt_d     = GAP_LOAD;
                  tone_en_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end else begin
               state_d = PLAY;
            end
         end
         GAP: begin
            tone_en_d = 1'b0;
            if (cnt_q == '0) begin
               state_d     = IDLE;
               note_done_d = 1'b1;
            end else if (tick) begin
               if (cnt_q == CNT_ONE) begin
                  state_d     = IDLE;
                  note_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end else begin
               state_d = GAP;
            end
         end
         default: begin
            state_d   = IDLE;
            cnt_d     = '0;
            tone_en_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset silences the generator immediately.
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         tone_period_q <= '0;
         tone_en_q     <= 1'b0;
         note_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tone_period_q <= tone_period_d;
         tone_en_q     <= tone_en_d;
         note_done_q   <= note_done_d;
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign tone_period = tone_period_q;
   assign tone_en     = tone_en_q;
   assign note_done   = note_done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: a note-level reference model queues the
// expected period, sounding time and busy time; a monitor measures each note.
module tb_tone_sequencer;

   localparam int CPT = 12;   // clocks per tick with the simulation override
   localparam int GAP = 2;

   logic        CLK_IN = 1'b0;
   logic        RST_N = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_note = 4'd0;
   logic [2:0]  cmd_octave = 3'd0;
   logic [11:0] cmd_dur = 12'd0;
   logic [19:0] tone_period;
   logic        tone_en;
   logic        busy;
   logic        note_done;

   tone_sequencer #(
      .MAIN_CLK_FREQ (12000),
      .TICK_HZ       (1000),
      .GAP_TICKS     (GAP),
      .PERIOD_W      (20),
      .DUR_W         (12)
   ) dut (
      .CLK_IN      (CLK_IN),
      .RST_N       (RST_N),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_note    (cmd_note),
      .cmd_octave  (cmd_octave),
      .cmd_dur     (cmd_dur),
      .tone_period (tone_period),
      .tone_en     (tone_en),
      .busy        (busy),
      .note_done   (note_done)
   );

   always #5 CLK_IN = ~CLK_IN;

   typedef struct {
      int id;
      int period;
      int en_cycles;
      int busy_cycles;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   model_period = 0;
   int   note_id = 0;

   task automatic check(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Equal-tempered pitch relative to A0 = 27.5 Hz, period in 12 MHz clocks.
   function automatic int ref_period(input int note, input int oct);
      real f;
      int  base;
      f    = 27.5 * (2.0 ** ((note - 9) / 12.0));
      base = $rtoi(12.0e6 / f + 0.5);
      return base >> oct;
   endfunction

   task automatic wait_accept(input string name);
      int n;
      n = 0;
      do begin
         @(negedge CLK_IN);
         n++;
      end while (!cmd_ready && n < 1000);
      check(name, int'(cmd_ready), 1);
      @(posedge CLK_IN);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send(input int note, input int oct, input int dur);
      exp_t e;
      if (note < 12) model_period = ref_period(note, oct);
      e.id          = note_id;
      e.period      = model_period;
      e.en_cycles   = (note < 12 && dur > 0) ? dur * CPT : 0;
      e.busy_cycles = (dur + GAP) * CPT;
      exp_q.push_back(e);
      note_id++;
      cmd_note   = 4'(note);
      cmd_octave = 3'(oct);
      cmd_dur    = 12'(dur);
      cmd_valid  = 1'b1;
      wait_accept("accept_wait");
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge CLK_IN);
         n++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge CLK_IN);
      #1;
   endtask

   // Monitor: measures each accepted note and scores it when note_done appears.
   int in_note = 0;
   int sample_n, en_n, busy_n, bad_n, en_fell, first_period;
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK_IN);
         if (!RST_N) begin
            in_note = 0;
         end else begin
            if (in_note != 0) begin
               sample_n++;
               if (sample_n == 1) first_period = int'(tone_period);
               else if (int'(tone_period) != first_period) bad_n++;
               if (tone_en) begin
                  en_n++;
                  if (en_fell != 0) bad_n++;
               end else begin
                  en_fell = 1;
               end
               if (note_done) begin
                  if (busy || !cmd_ready) bad_n++;
                  in_note = 0;
                  check("done_has_expectation", int'(exp_q.size() > 0), 1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     check($sformatf("note%0d_period", e.id), first_period, e.period);
                     check($sformatf("note%0d_en_cycles", e.id), en_n, e.en_cycles);
                     check($sformatf("note%0d_busy_cycles", e.id), busy_n, e.busy_cycles);
                     check($sformatf("note%0d_sequence_errors", e.id), bad_n, 0);
                  end
               end else if (busy) begin
                  busy_n++;
                  if (cmd_ready) bad_n++;
               end else begin
                  bad_n++;
               end
            end else if (note_done || tone_en) begin
               check("idle_quiet", int'({note_done, tone_en}), 0);
            end
            if (cmd_valid && cmd_ready) begin
               in_note      = 1;
               sample_n     = 0;
               en_n         = 0;
               busy_n       = 0;
               bad_n        = 0;
               en_fell      = 0;
               first_period = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
      $fatal(1, "tb_tone_sequencer timeout");
   end

   initial begin : stimulus
      repeat (3) @(negedge CLK_IN);
      check("rst_tone_en", int'(tone_en), 0);
      check("rst_tone_period", int'(tone_period), 0);
      check("rst_busy", int'(busy), 0);
      #2 RST_N = 1'b1;
      repeat (2) @(negedge CLK_IN);
      check("idle_tone_en", int'(tone_en), 0);
      check("idle_tone_period", int'(tone_period), 0);
      check("idle_cmd_ready", int'(cmd_ready), 1);
      check("idle_busy", int'(busy), 0);
      check("idle_note_done", int'(note_done), 0);
      @(posedge CLK_IN);
      #1;

      // Directed notes; consecutive sends keep cmd_valid high while busy.
      send(9, 4, 3);
      wait_drain();
      send(0, 0, 1);
      send(11, 7, 1);
      send(9, 4, 1);
      send(12, 0, 2);
      send(5, 2, 0);
      send(13, 3, 0);
      wait_drain();

      for (int i = 0; i < 30; i++) begin
         send(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 4)));
         if ($urandom_range(0, 1) == 0) wait_drain();
      end
      wait_drain();

      // Asynchronous reset in the middle of a sounding note.
      cmd_note   = 4'd9;
      cmd_octave = 3'd4;
      cmd_dur    = 12'd3;
      cmd_valid  = 1'b1;
      wait_accept("raw_accept_wait");
      repeat (10) @(negedge CLK_IN);
      check("pre_reset_tone_en", int'(tone_en), 1);
      #2 RST_N = 1'b0;
      #1;
      check("async_rst_tone_en", int'(tone_en), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_cmd_ready", int'(cmd_ready), 1);
      check("async_rst_tone_period", int'(tone_period), 0);
      model_period = 0;
      @(negedge CLK_IN);
      #2 RST_N = 1'b1;
      @(posedge CLK_IN);
      #1;
      send(12, 0, 1);
      send(9, 4, 2);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
